// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: op encodings and lane masks.
package wb_stage_pkg;

  typedef enum logic [3:0] {
    WB_ALU  = 4'd0,
    WB_LB   = 4'd1,
    WB_LBU  = 4'd2,
    WB_LH   = 4'd3,
    WB_LHU  = 4'd4,
    WB_LW   = 4'd5,
    WB_LWL  = 4'd6,
    WB_LWR  = 4'd7,
    WB_NOWB = 4'd8
  } wb_op_e;

  localparam logic [3:0] LANES_ALL  = 4'b1111;
  localparam logic [3:0] LANES_NONE = 4'b0000;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage to writeback-stage handshake bundle.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_op;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_addr_lo;

  modport master (
    output mem_valid, mem_op, mem_dest, mem_result, mem_rdata, mem_addr_lo,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_op, mem_dest, mem_result, mem_rdata, mem_addr_lo,
    output mem_ready
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Load data alignment/extension and byte-lane mask generation (purely combinational).
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] result,
  output logic [31:0] data,
  output logic [3:0]  mask,
  output logic        misaligned
);

  logic [4:0]  sh_r;
  logic [4:0]  sh_l;
  logic [1:0]  inv_a;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    inv_a    = 2'd3 - addr_lo;
    sh_r     = {addr_lo, 3'b000};
    sh_l     = {inv_a, 3'b000};
    byte_sel = rdata[sh_r +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data       = 32'h0;
    mask       = LANES_NONE;
    misaligned = 1'b0;
    case (op)
      WB_ALU: begin
        data = result;
        mask = LANES_ALL;
      end
      WB_LB: begin
        data = {{24{byte_sel[7]}}, byte_sel};
        mask = LANES_ALL;
      end
      WB_LBU: begin
        data = {24'h0, byte_sel};
        mask = LANES_ALL;
      end
      WB_LH, WB_LHU: begin
        data       = {{16{half_sel[15] && (op == WB_LH)}}, half_sel};
        misaligned = addr_lo[0];
        mask       = misaligned ? LANES_NONE : LANES_ALL;
      end
      WB_LW: begin
        data       = rdata;
        misaligned = (addr_lo != 2'd0);
        mask       = misaligned ? LANES_NONE : LANES_ALL;
      end
      // Unaligned word halves: merge only the lanes this access supplies.
      WB_LWL: begin
        data = rdata << sh_l;
        mask = LANES_ALL << inv_a;
      end
      WB_LWR: begin
        data = rdata >> sh_r;
        mask = LANES_ALL >> addr_lo;
      end
      default: begin
        data = 32'h0;
        mask = LANES_NONE;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: single stage register, halt control, register-file write and forwarding tap.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  wb_stage_if.slave        mem,
  input  logic             halt,
  output logic [3:0]       rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_dest,
  output logic [31:0]      fwd_data,
  output logic             fwd_partial,
  output logic             misalign,
  output logic [CNT_W-1:0] retired
);

  logic             wb_valid_q;
  logic [3:0]       op_q;
  logic [4:0]       dest_q;
  logic [31:0]      result_q;
  logic [31:0]      rdata_q;
  logic [1:0]       addr_q;
  logic [CNT_W-1:0] retired_q;

  logic [31:0] al_data;
  logic [3:0]  al_mask;
  logic        al_mis;
  logic [3:0]  eff_wen;
  logic        accept;
  logic        complete;

  wb_stage_load_align u_align (
    .op         (op_q),
    .addr_lo    (addr_q),
    .rdata      (rdata_q),
    .result     (result_q),
    .data       (al_data),
    .mask       (al_mask),
    .misaligned (al_mis)
  );

  assign mem.mem_ready = !wb_valid_q || !halt;

  always_comb begin
    accept      = mem.mem_valid && mem.mem_ready;
    complete    = wb_valid_q && !halt;
    eff_wen     = ((dest_q == 5'd0) || al_mis) ? LANES_NONE : al_mask;
    rf_wen      = complete ? eff_wen : LANES_NONE;
    rf_waddr    = dest_q;
    rf_wdata    = al_data;
    fwd_valid   = wb_valid_q && (eff_wen != LANES_NONE);
    fwd_dest    = dest_q;
    fwd_data    = al_data;
    fwd_partial = fwd_valid && (eff_wen != LANES_ALL);
    misalign    = complete && al_mis;
    retired     = retired_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_valid_q <= 1'b0;
      op_q       <= 4'd0;
      dest_q     <= 5'd0;
      result_q   <= 32'h0;
      rdata_q    <= 32'h0;
      addr_q     <= 2'd0;
      retired_q  <= '0;
    end else begin
      // A completing instruction is simply overwritten by a new transfer.
      if (accept) begin
        wb_valid_q <= 1'b1;
        op_q       <= mem.mem_op;
        dest_q     <= mem.mem_dest;
        result_q   <= mem.mem_result;
        rdata_q    <= mem.mem_rdata;
        addr_q     <= mem.mem_addr_lo;
      end else if (complete) begin
        wb_valid_q <= 1'b0;
      end
      if (complete) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk;
  logic        resetn;
  logic        halt;
  logic [3:0]  rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        fwd_partial;
  logic        misalign;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  wb_stage_if mif ();

  wb_stage #(.CNT_W(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem         (mif.slave),
    .halt        (halt),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fwd_valid   (fwd_valid),
    .fwd_dest    (fwd_dest),
    .fwd_data    (fwd_data),
    .fwd_partial (fwd_partial),
    .misalign    (misalign),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an instruction, let it transfer, land #1 into its completion cycle.
  task automatic issue(input logic [3:0] op, input logic [4:0] dest, input logic [31:0] res,
                       input logic [31:0] rd, input logic [1:0] a);
    mif.mem_valid   = 1'b1;
    mif.mem_op      = op;
    mif.mem_dest    = dest;
    mif.mem_result  = res;
    mif.mem_rdata   = rd;
    mif.mem_addr_lo = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mif.mem_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn          = 1'b0;
    halt            = 1'b0;
    mif.mem_valid   = 1'b0;
    mif.mem_op      = 4'd0;
    mif.mem_dest    = 5'd0;
    mif.mem_result  = 32'h0;
    mif.mem_rdata   = 32'h0;
    mif.mem_addr_lo = 2'd0;
    #3;
    chk("rst_ready",   32'(mif.mem_ready), 32'd1);
    chk("rst_wen",     32'(rf_wen), 32'd0);
    chk("rst_fwdv",    32'(fwd_valid), 32'd0);
    chk("rst_part",    32'(fwd_partial), 32'd0);
    chk("rst_mis",     32'(misalign), 32'd0);
    chk("rst_waddr",   32'(rf_waddr), 32'd0);
    chk("rst_wdata",   rf_wdata, 32'd0);
    chk("rst_fdest",   32'(fwd_dest), 32'd0);
    chk("rst_fdata",   fwd_data, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    issue(WB_ALU, 5'd5, 32'h12345678, 32'h0, 2'd0);
    chk("alu_wen",   32'(rf_wen), 32'hF);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata, 32'h12345678);
    chk("alu_fwdv",  32'(fwd_valid), 32'd1);
    chk("alu_part",  32'(fwd_partial), 32'd0);
    idle();
    chk("alu_ret",   retired, 32'd1);
    chk("idle_wen",  32'(rf_wen), 32'd0);
    chk("idle_fwdv", 32'(fwd_valid), 32'd0);

    issue(WB_LB, 5'd1, 32'h0, 32'h80FF7F01, 2'd3);
    chk("lb_wdata", rf_wdata, 32'hFFFFFF80);
    chk("lb_wen",   32'(rf_wen), 32'hF);
    issue(WB_LBU, 5'd2, 32'h0, 32'h80FF7F01, 2'd2);
    chk("lbu_wdata", rf_wdata, 32'h000000FF);
    issue(WB_LH, 5'd3, 32'h0, 32'h80FF7F01, 2'd2);
    chk("lh_wdata", rf_wdata, 32'hFFFF80FF);
    chk("lh_wen",   32'(rf_wen), 32'hF);
    issue(WB_LHU, 5'd4, 32'h0, 32'h80FF7F01, 2'd0);
    chk("lhu_wdata", rf_wdata, 32'h00007F01);
    issue(WB_LWL, 5'd6, 32'h0, 32'hAABBCCDD, 2'd1);
    chk("lwl_wdata", rf_wdata, 32'hCCDD0000);
    chk("lwl_wen",   32'(rf_wen), 32'hC);
    chk("lwl_part",  32'(fwd_partial), 32'd1);
    chk("lwl_fdata", fwd_data, 32'hCCDD0000);
    issue(WB_LWR, 5'd7, 32'h0, 32'hAABBCCDD, 2'd2);
    chk("lwr_wdata", rf_wdata, 32'h0000AABB);
    chk("lwr_wen",   32'(rf_wen), 32'h3);
    chk("lwr_part",  32'(fwd_partial), 32'd1);
    idle();
    chk("loads_ret", retired, 32'd7);

    issue(WB_LW, 5'd3, 32'h0, 32'h11223344, 2'd2);
    chk("lwmis_wen",  32'(rf_wen), 32'd0);
    chk("lwmis_mis",  32'(misalign), 32'd1);
    chk("lwmis_fwdv", 32'(fwd_valid), 32'd0);
    idle();
    chk("lwmis_pulse", 32'(misalign), 32'd0);
    chk("lwmis_ret",   retired, 32'd8);

    issue(WB_ALU, 5'd0, 32'hCAFEF00D, 32'h0, 2'd0);
    chk("d0_wen",  32'(rf_wen), 32'd0);
    chk("d0_fwdv", 32'(fwd_valid), 32'd0);
    idle();
    chk("d0_ret", retired, 32'd9);

    for (int i = 0; i < 4; i++) begin
      issue(WB_ALU, 5'(10 + i), 32'hA000_0000 + 32'(i), 32'h0, 2'd0);
      chk("b2b_wen",   32'(rf_wen), 32'hF);
      chk("b2b_waddr", 32'(rf_waddr), 32'(10 + i));
      chk("b2b_wdata", rf_wdata, 32'hA000_0000 + 32'(i));
    end
    idle();
    chk("b2b_ret", retired, 32'd13);

    issue(WB_ALU, 5'd20, 32'hDEADBEEF, 32'h0, 2'd0);
    halt          = 1'b1;
    mif.mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_ready", 32'(mif.mem_ready), 32'd0);
      chk("halt_wen",   32'(rf_wen), 32'd0);
      chk("halt_fdest", 32'(fwd_dest), 32'd20);
      chk("halt_fwdv",  32'(fwd_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("halt_ret", retired, 32'd13);
    halt = 1'b0;
    #1;
    chk("rel_wen",   32'(rf_wen), 32'hF);
    chk("rel_waddr", 32'(rf_waddr), 32'd20);
    chk("rel_wdata", rf_wdata, 32'hDEADBEEF);
    idle();
    chk("rel_ret",  retired, 32'd14);
    chk("rel_fwdv", 32'(fwd_valid), 32'd0);

    // Halted but empty: a transfer is still taken.
    halt = 1'b1;
    #1;
    chk("hempty_ready", 32'(mif.mem_ready), 32'd1);
    issue(WB_ALU, 5'd7, 32'h00000077, 32'h0, 2'd0);
    mif.mem_valid = 1'b0;
    chk("hempty_fwdv", 32'(fwd_valid), 32'd1);
    chk("hempty_wen",  32'(rf_wen), 32'd0);
    halt = 1'b0;
    #1;
    chk("hempty_rel", 32'(rf_wen), 32'hF);
    idle();
    chk("hempty_ret", retired, 32'd15);

    issue(WB_LW, 5'd9, 32'h0, 32'h11223344, 2'd0);
    halt          = 1'b1;
    mif.mem_valid = 1'b0;
    #1;
    chk("pre_rst_fwdv", 32'(fwd_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("arst_fwdv",  32'(fwd_valid), 32'd0);
    chk("arst_wen",   32'(rf_wen), 32'd0);
    chk("arst_fdata", fwd_data, 32'd0);
    chk("arst_ret",   retired, 32'd0);
    #1;
    resetn = 1'b1;
    halt   = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_wen",  32'(rf_wen), 32'd0);
    chk("post_rst_fwdv", 32'(fwd_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_ret", retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
